muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide engine, WIDTH-bit operands, with a 2·WIDTH-bit HI/LO result. It serves MIPS MULT/MULTU/DIV/DIVU from one datapath that is shared between the two operations. It sits beside the ALU in the multicycle CPU: the control unit pulses `start` with the A/B register values and waits for `done`, then the result is written into the HI/LO registers. Compared with the fixed 32-bit signed-only units it replaces, it adds a width parameter, unsigned modes, a busy flag, and defined overflow/zero-divisor behaviour.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_absneg.sv | 16 +
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multicycle MULT/MULTU/DIV/DIVU engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    ZERO
  } state_e;

  function automatic logic is_div(op_e o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic is_signed_op(op_e o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Two's-complement conditional negate: yields |x| for a negative input when neg
// is its sign bit, or flips a result's sign during correction.
module muldiv_absneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  logic signed [W-1:0] xs;

  assign xs = $signed(x);
  assign y  = neg ? $unsigned(-xs) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Shared-datapath multicycle multiplier/divider: shift-add multiply and restoring
// divide on unsigned magnitudes, with sign fix-up in a final cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state, state_nxt;
  op_e                op_in, op_q;
  logic               a_neg, b_neg, div_by_zero;
  logic               q_neg, r_neg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   divr;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               load, step, commit, busy_nxt, done_nxt, dz_nxt;

  assign op_in       = op_e'(op);
  assign a_neg       = is_signed_op(op_in) & a[WIDTH-1];
  assign b_neg       = is_signed_op(op_in) & b[WIDTH-1];
  assign div_by_zero = is_div(op_in) && (b == '0);

  muldiv_absneg #(.W(WIDTH)) u_abs_a (.x(a), .neg(a_neg), .y(mag_a));
  muldiv_absneg #(.W(WIDTH)) u_abs_b (.x(b), .neg(b_neg), .y(mag_b));

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divr} : '0);
  assign mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, divr};
  assign div_nxt  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_absneg #(.W(2*WIDTH)) u_fix_prod (.x(acc), .neg(q_neg), .y(prod_fix));
  muldiv_absneg #(.W(WIDTH)) u_fix_quo (.x(acc[WIDTH-1:0]), .neg(q_neg), .y(quo_fix));
  muldiv_absneg #(.W(WIDTH)) u_fix_rem (.x(acc[2*WIDTH-1:WIDTH]), .neg(r_neg), .y(rem_fix));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_by_zero ? ZERO : RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    done_nxt = 1'b0;
    dz_nxt   = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    case (state)
      IDLE: load = start;
      RUN:  step = 1'b1;
      FIX: begin
        commit   = 1'b1;
        done_nxt = 1'b1;
      end
      ZERO: begin
        done_nxt = 1'b1;
        dz_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= MULT;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      divr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      div_zero <= dz_nxt;
      if (load) begin
        op_q  <= op_in;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        cnt   <= CNT_W'(WIDTH);
        acc   <= {{WIDTH{1'b0}}, mag_a};
        divr  <= mag_b;
      end
      if (step) begin
        cnt <= cnt - CNT_W'(1);
        acc <= is_div(op_q) ? div_nxt : mul_nxt;
      end
      if (commit) begin
        if (is_div(op_q)) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_muldiv_unit;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clock, reset;
  logic        start32, start8;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q32[$];
  exp_t q8[$];
  logic [31:0] last_hi32 = 0, last_lo32 = 0, last_hi8 = 0, last_lo8 = 0;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op_i), .a(a_i[7:0]), .b(b_i[7:0]),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Reference arithmetic on w-bit values (w <= 32); truncating division from SV / and %.
  task automatic model(input int w, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] mh, output logic [31:0] ml);
    longint unsigned mask, ua, ub, full, rh, rl;
    longint          sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, av} & mask;
    ub = {32'd0, bv} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    rh = 0;
    rl = 0;
    case (o)
      2'd0: begin full = longint'(sa * sb); rl = full; rh = full >> w; end
      2'd1: begin full = ua * ub; rl = full; rh = full >> w; end
      2'd2: begin rl = longint'(sa / sb); rh = longint'(sa % sb); end
      default: begin rl = ua / ub; rh = ua % ub; end
    endcase
    mh = 32'(rh & mask);
    ml = 32'(rl & mask);
  endtask

  task automatic issue(input int w, input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input bit glitch, input bit fixed, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t        e;
    int          n;
    logic [31:0] mh, ml, bm;
    n = 0;
    @(negedge clock);
    while ((w == 8 ? busy8 : busy32) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("idle_wait", 64'd1, 64'd0);
    op_i = o;
    a_i  = av;
    b_i  = bv;
    if (w == 8) start8 = 1'b1;
    else        start32 = 1'b1;
    @(posedge clock);
    #1;
    start8  = 1'b0;
    start32 = 1'b0;
    bm = (w == 8) ? {24'd0, bv[7:0]} : bv;
    e.dz = o[1] && (bm == 0);
    e.cyc = cyc + (e.dz ? 1 : w + 1);
    if (e.dz) begin
      mh = (w == 8) ? last_hi8 : last_hi32;
      ml = (w == 8) ? last_lo8 : last_lo32;
    end else begin
      model(w, o, av, bv, mh, ml);
    end
    if (fixed) begin
      mh = ehi;
      ml = elo;
    end
    e.hi = mh;
    e.lo = ml;
    if (w == 8) begin last_hi8 = mh; last_lo8 = ml; q8.push_back(e); end
    else begin last_hi32 = mh; last_lo32 = ml; q32.push_back(e); end
    a_i = $urandom;
    b_i = $urandom;
    op_i = 2'($urandom_range(0, 3));
    if (glitch) begin
      repeat (9) @(negedge clock);
      a_i = $urandom;
      b_i = $urandom;
      if (w == 8) start8 = 1'b1;
      else        start32 = 1'b1;
      @(posedge clock);
      #1;
      start8  = 1'b0;
      start32 = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("drain_queues", 64'(q32.size() + q8.size()), 64'd0);
  endtask

  always @(negedge clock) begin
    if (reset && done32) begin
      if (q32.size() == 0) check("unexpected_done32", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q32.pop_front();
        check("cyc32", 64'(cyc), 64'(e.cyc));
        check("dz32", 64'(dz32), 64'(e.dz));
        check("hi32", 64'(hi32), 64'(e.hi));
        check("lo32", 64'(lo32), 64'(e.lo));
      end
    end
    if (reset && done8) begin
      if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check("cyc8", 64'(cyc), 64'(e.cyc));
        check("dz8", 64'(dz8), 64'(e.dz));
        check("hi8", 64'(hi8), 64'(e.hi));
        check("lo8", 64'(lo8), 64'(e.lo));
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    reset   = 1'b0;
    start32 = 1'b0;
    start8  = 1'b0;
    op_i    = 2'd0;
    a_i     = 32'd0;
    b_i     = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_hilo", {hi32, lo32}, 64'd0);
    reset = 1'b1;

    issue(32, 2'd0, 32'hFFFF_FFFD, 32'd5, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(32, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(32, 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(32, 2'd3, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'h0000_0001, 32'h7FFF_FFFC);
    issue(32, 2'd3, 32'd7, 32'd3, 0, 1, 32'd1, 32'd2);
    issue(32, 2'd3, 32'd100, 32'd0, 0, 1, 32'd1, 32'd2);
    issue(32, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'd0, 32'h8000_0000);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      issue(32, ro, ra, rb, 0, 0, 32'd0, 32'd0);
    end

    drain();
    @(negedge clock);
    op_i = 2'd0;
    a_i = 32'd1234567;
    b_i = 32'd89;
    start32 = 1'b1;
    @(posedge clock);
    #1;
    start32 = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    check("abort_hilo", {hi32, lo32}, 64'd0);
    last_hi32 = 0; last_lo32 = 0; last_hi8 = 0; last_lo8 = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_idle", 64'(busy32), 64'd0);
    issue(32, 2'd0, 32'd6, 32'd7, 0, 1, 32'd0, 32'd42);

    issue(8, 2'd0, 32'd6, 32'd7, 0, 1, 32'd0, 32'd42);
    issue(8, 2'd2, 32'h80, 32'hFF, 0, 1, 32'd0, 32'h80);
    issue(8, 2'd3, 32'd9, 32'd0, 0, 1, 32'd0, 32'h80);
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      issue(8, ro, ra, rb, 0, 0, 32'd0, 32'd0);
    end

    drain();
    repeat (5) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
